// File: rtl/ntt_basemul_if.sv
// Bus bundle for the ML-KEM base-case multiplier: operand reads from the
// A/B polynomial BRAMs and the gamma ROM, result writes to the C BRAM, and
// the start/busy/done control handshake.
interface ntt_basemul_if #(
   parameter int WIDTH      = 16,
   parameter int WIDTH_ADDR = 7
) ();

   logic                    start;
   logic                    rd_en;
   logic [WIDTH_ADDR-1:0]   rd_addr;
   logic [2*WIDTH-1:0]      a_rdata;
   logic [2*WIDTH-1:0]      b_rdata;
   logic [WIDTH-1:0]        gamma;
   logic                    wr_en;
   logic [WIDTH_ADDR-1:0]   wr_addr;
   logic [2*WIDTH-1:0]      wr_data;
   logic                    busy;
   logic                    done;

   // Multiplier side: issues reads and writes, reports status.
   modport master (
      input  start,
      input  a_rdata,
      input  b_rdata,
      input  gamma,
      output rd_en,
      output rd_addr,
      output wr_en,
      output wr_addr,
      output wr_data,
      output busy,
      output done
   );

   // Memory/controller side: answers reads, starts runs, absorbs writes.
   modport slave (
      output start,
      output a_rdata,
      output b_rdata,
      output gamma,
      input  rd_en,
      input  rd_addr,
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  busy,
      input  done
   );

endinterface

// File: rtl/ntt_basemul.sv
// Pointwise base-case multiplier for ML-KEM polynomials in the NTT domain.
// For each pair index i it reads {a1,a0}, {b1,b0} and gamma_i and writes
//    c0 = (a0*b0 + (a1*b1 mod Q)*gamma_i) mod Q
//    c1 = (a0*b1 + a1*b0) mod Q
// Reads stream one pair per cycle for NPAIR cycles; each result is written
// exactly three cycles after its read strobe. The memory output register
// acts as the operand stage, so the two internal stages are the product
// register and the reduced result register.
module ntt_basemul #(
   parameter int WIDTH      = 16,
   parameter int Q          = 3329,
   parameter int NPAIR      = 128,
   parameter int WIDTH_ADDR = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   ntt_basemul_if.master     bus
);

   // Reduction input width: wide enough for a sum of two full products.
   localparam int RW = 2*WIDTH + 2;
   // Barrett constant floor(2^RW / Q); RW stays below 64 for WIDTH <= 30.
   localparam logic [63:0]           BARRETT_M = (64'd1 << RW) / 64'(Q);
   localparam logic [RW-1:0]         Q_RW      = RW'(Q);
   localparam logic [WIDTH_ADDR-1:0] LAST_ADDR = WIDTH_ADDR'(NPAIR - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Barrett reduction of x < 2^RW to [0, Q). The quotient estimate is at
   // most one short, so one conditional subtraction finishes the job.
   function automatic logic [WIDTH-1:0] mod_q(input logic [RW-1:0] x);
      logic [2*RW-1:0] prod;
      logic [RW-1:0]   qhat;
      logic [RW-1:0]   r;
      prod = (2*RW)'(x) * (2*RW)'(BARRETT_M);
      qhat = RW'(prod >> RW);
      r    = x - (qhat * Q_RW);
      if (r >= Q_RW) begin
         r = r - Q_RW;
      end else begin
         r = r;
      end
      return r[WIDTH-1:0];
   endfunction

   // Control registers
   state_t                  r_state;
   logic                    r_rd_en;
   logic [WIDTH_ADDR-1:0]   r_rd_addr;
   logic                    r_busy;
   logic                    r_done;

   // Operand-valid stage (memory outputs valid this cycle)
   logic                    r_v_data;
   logic [WIDTH_ADDR-1:0]   r_addr_data;

   // Product stage
   logic                    r_v_prod;
   logic [WIDTH_ADDR-1:0]   r_addr_prod;
   logic [2*WIDTH-1:0]      r_p00;
   logic [2*WIDTH-1:0]      r_p10;
   logic [2*WIDTH-1:0]      r_p01;
   logic [WIDTH-1:0]        r_t11;
   logic [WIDTH-1:0]        r_g;

   // Result stage
   logic                    r_wr_en;
   logic [WIDTH_ADDR-1:0]   r_wr_addr;
   logic [2*WIDTH-1:0]      r_wr_data;

   // Operand split
   logic [WIDTH-1:0]        w_a0;
   logic [WIDTH-1:0]        w_a1;
   logic [WIDTH-1:0]        w_b0;
   logic [WIDTH-1:0]        w_b1;

   // Products formed from the memory outputs
   logic [2*WIDTH-1:0]      w_p00;
   logic [2*WIDTH-1:0]      w_p10;
   logic [2*WIDTH-1:0]      w_p01;
   logic [WIDTH-1:0]        w_t11;

   // Combine and reduce
   logic [RW-1:0]           w_s0;
   logic [RW-1:0]           w_s1;
   logic [WIDTH-1:0]        w_c0;
   logic [WIDTH-1:0]        w_c1;

   assign w_a0 = bus.a_rdata[WIDTH-1:0];
   assign w_a1 = bus.a_rdata[2*WIDTH-1:WIDTH];
   assign w_b0 = bus.b_rdata[WIDTH-1:0];
   assign w_b1 = bus.b_rdata[2*WIDTH-1:WIDTH];

   assign w_p00 = (2*WIDTH)'(w_a0) * (2*WIDTH)'(w_b0);
   assign w_p10 = (2*WIDTH)'(w_a1) * (2*WIDTH)'(w_b0);
   assign w_p01 = (2*WIDTH)'(w_a0) * (2*WIDTH)'(w_b1);
   assign w_t11 = mod_q(RW'(w_a1) * RW'(w_b1));

   // a1*b1 is already reduced, so t11*gamma stays below Q*2^WIDTH.
   assign w_s0 = RW'(r_p00) + (RW'(r_t11) * RW'(r_g));
   assign w_s1 = RW'(r_p10) + RW'(r_p01);
   assign w_c0 = mod_q(w_s0);
   assign w_c1 = mod_q(w_s1);

   // Run sequencer: address generation, busy and done, all registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_state   <= S_RUN;
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= '0;
                  r_busy    <= 1'b1;
               end else begin
                  r_rd_en <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end
            S_RUN: begin
               // Stop on the last pair; the address holds instead of wrapping.
               if (r_rd_addr == LAST_ADDR) begin
                  r_state <= S_DRAIN;
                  r_rd_en <= 1'b0;
               end else begin
                  r_rd_addr <= r_rd_addr + WIDTH_ADDR'(1);
               end
            end
            S_DRAIN: begin
               // The result register writes its last pair while we leave.
               if (!r_v_data && !r_v_prod) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_DRAIN;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_rd_en <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Datapath pipeline: valid/address tracking, products, reduced result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v_data    <= 1'b0;
         r_addr_data <= '0;
         r_v_prod    <= 1'b0;
         r_addr_prod <= '0;
         r_p00       <= '0;
         r_p10       <= '0;
         r_p01       <= '0;
         r_t11       <= '0;
         r_g         <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
      end else begin
         r_v_data    <= r_rd_en;
         r_addr_data <= r_rd_addr;
         r_v_prod    <= r_v_data;
         r_addr_prod <= r_addr_data;
         r_wr_en     <= r_v_prod;
         if (r_v_data) begin
            r_p00 <= w_p00;
            r_p10 <= w_p10;
            r_p01 <= w_p01;
            r_t11 <= w_t11;
            r_g   <= bus.gamma;
         end
         if (r_v_prod) begin
            r_wr_addr <= r_addr_prod;
            r_wr_data <= {w_c1, w_c0};
         end
      end
   end

   assign bus.rd_en   = r_rd_en;
   assign bus.rd_addr = r_rd_addr;
   assign bus.wr_en   = r_wr_en;
   assign bus.wr_addr = r_wr_addr;
   assign bus.wr_data = r_wr_data;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;

endmodule

// File: tb/tb_ntt_basemul.sv
// Bench for ntt_basemul: BRAM/ROM models with one-cycle read latency, a
// scoreboard fed on every read strobe and drained on every write, and
// cycle-exact checks of the run timing, mid-run reset and start-while-busy.
module tb_ntt_basemul;

   localparam int W  = 16;
   localparam int AW = 7;
   localparam int NP = 128;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   ntt_basemul_if #(.WIDTH(W), .WIDTH_ADDR(AW)) bus ();

   ntt_basemul #(.WIDTH(W), .Q(3329), .NPAIR(NP), .WIDTH_ADDR(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int              rd_cyc;
      logic [AW-1:0]   addr;
      logic [2*W-1:0]  data;
   } sb_entry_t;

   logic [W-1:0]   mem_a0 [NP];
   logic [W-1:0]   mem_a1 [NP];
   logic [W-1:0]   mem_b0 [NP];
   logic [W-1:0]   mem_b1 [NP];
   logic [W-1:0]   mem_g  [NP];
   logic [2*W-1:0] cap    [NP];
   sb_entry_t      sb_q   [$];
   sb_entry_t      mon_e;

   int cyc_cnt  = 0;
   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int d0;

   // Reference result with plain % arithmetic.
   function automatic logic [31:0] model(input logic [15:0] a0, input logic [15:0] a1,
                                         input logic [15:0] b0, input logic [15:0] b1,
                                         input logic [15:0] g);
      logic [63:0] t;
      logic [63:0] c0;
      logic [63:0] c1;
      t  = (64'(a1) * 64'(b1)) % 64'd3329;
      c0 = (64'(a0) * 64'(b0) + t * 64'(g)) % 64'd3329;
      c1 = (64'(a0) * 64'(b1) + 64'(a1) * 64'(b0)) % 64'd3329;
      return {c1[15:0], c0[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic fill_mem(input bit fixed_head);
      for (int i = 0; i < NP; i++) begin
         mem_a0[i] = 16'($urandom_range(0, 3328));
         mem_a1[i] = 16'($urandom_range(0, 3328));
         mem_b0[i] = 16'($urandom_range(0, 3328));
         mem_b1[i] = 16'($urandom_range(0, 3328));
         mem_g[i]  = 16'($urandom_range(0, 3328));
      end
      if (fixed_head) begin
         mem_a0[0] = 16'd1;    mem_a1[0] = 16'd1;    mem_b0[0] = 16'd1;    mem_b1[0] = 16'd1;
         mem_g[0]  = 16'd17;
         mem_a0[1] = 16'd3328; mem_a1[1] = 16'd3328; mem_b0[1] = 16'd3328; mem_b1[1] = 16'd3328;
         mem_g[1]  = 16'd17;
         mem_a0[2] = 16'd3328; mem_a1[2] = 16'd3328; mem_b0[2] = 16'd3328; mem_b1[2] = 16'd3328;
         mem_g[2]  = 16'd3312;
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_rd_en"},   64'(bus.rd_en),   64'd0);
      chk({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
      chk({tag, "_wr_en"},   64'(bus.wr_en),   64'd0);
      chk({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
      chk({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
      chk({tag, "_busy"},    64'(bus.busy),    64'd0);
      chk({tag, "_done"},    64'(bus.done),    64'd0);
   endtask

   // Pulse start in cycle 0 and check every control output per cycle. With
   // restart set, start is raised again in cycle 50 and held through DONE,
   // so a second run must begin reading in cycle 134.
   task automatic run_timed(input bit restart);
      int  last_c;
      bit  exp_rd;
      bit  exp_busy;
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      last_c = restart ? 136 : 133;
      for (int c = 1; c <= last_c; c++) begin
         @(negedge clk);
         exp_rd   = (c <= 128) || (restart && c >= 134);
         exp_busy = (c <= 131) || (restart && c >= 134);
         chk("rd_en", 64'(bus.rd_en), 64'(exp_rd));
         if (exp_rd) begin
            chk("rd_addr", 64'(bus.rd_addr), 64'((c <= 128) ? c - 1 : c - 134));
         end
         chk("busy",  64'(bus.busy),  64'(exp_busy));
         chk("done",  64'(bus.done),  64'(c == 132));
         chk("wr_en", 64'(bus.wr_en), 64'(c >= 4 && c <= 131));
         if (restart && c == 50) bus.start = 1'b1;
         if (restart && c == 135) bus.start = 1'b0;
      end
   endtask

   task automatic wait_done(input int bound);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < bound && !seen; k++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      chk("done_seen", 64'(seen), 64'd1);
      repeat (2) @(negedge clk);
   endtask

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // A/B BRAMs and gamma ROM: registered read, expected result queued per read.
   always @(posedge clk) begin
      if (bus.rd_en === 1'b1) begin
         bus.a_rdata <= {mem_a1[bus.rd_addr], mem_a0[bus.rd_addr]};
         bus.b_rdata <= {mem_b1[bus.rd_addr], mem_b0[bus.rd_addr]};
         bus.gamma   <= mem_g[bus.rd_addr];
         sb_q.push_back('{rd_cyc: cyc_cnt, addr: bus.rd_addr,
                          data: model(mem_a0[bus.rd_addr], mem_a1[bus.rd_addr],
                                      mem_b0[bus.rd_addr], mem_b1[bus.rd_addr],
                                      mem_g[bus.rd_addr])});
      end
   end

   // Result BRAM side: pop the scoreboard on every write and compare.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.done === 1'b1) done_cnt++;
         if (bus.wr_en === 1'b1) begin
            chk("wr_expected", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
               mon_e = sb_q.pop_front();
               chk("wr_latency", 64'(cyc_cnt - mon_e.rd_cyc), 64'd3);
               chk("wr_addr",    64'(bus.wr_addr), 64'(mon_e.addr));
               chk("wr_data",    64'(bus.wr_data), 64'(mon_e.data));
               chk("c0_range",   64'(bus.wr_data[15:0]  < 16'd3329), 64'd1);
               chk("c1_range",   64'(bus.wr_data[31:16] < 16'd3329), 64'd1);
               cap[bus.wr_addr] = bus.wr_data;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Test sequence.
   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      fill_mem(1'b1);
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      rst_n = 1'b1;

      // Timing, basic math, max operands, random pairs.
      run_timed(1'b0);
      chk("pair0_basic",  64'(cap[0]), 64'({16'd2, 16'd18}));
      chk("pair1_max",    64'(cap[1]), 64'({16'd2, 16'd18}));
      chk("pair2_neg17",  64'(cap[2]), 64'({16'd2, 16'd3313}));
      chk("sb_empty_1",   64'(sb_q.size()), 64'd0);

      // Mid-run reset in cycle 60.
      fill_mem(1'b0);
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (59) @(posedge clk);
      #1 rst_n = 1'b0;
      sb_q.delete();
      d0 = done_cnt;
      #1 check_zero("midrst");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         chk("post_rst_wr_en", 64'(bus.wr_en), 64'd0);
         chk("post_rst_rd_en", 64'(bus.rd_en), 64'd0);
      end
      chk("post_rst_done", 64'(done_cnt - d0), 64'd0);

      // Clean pass after the reset.
      run_timed(1'b0);
      chk("sb_empty_2", 64'(sb_q.size()), 64'd0);

      // Start while busy, then start held through DONE.
      fill_mem(1'b0);
      run_timed(1'b1);
      wait_done(300);
      chk("sb_empty_3", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
